// File: rtl/accel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// accel_ctrl_pkg : shared state encoding and width helper for accel_stream_ctrl
// Revision: 1.0
// ============================================================================
package accel_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_credit_counter.sv
`default_nettype none
// ============================================================================
// accel_credit_counter : in-flight result counter, underflow flag and the
//                        outBuf credit check that gates the input pop.
// Revision: 1.0
// ============================================================================
module accel_credit_counter
  import accel_ctrl_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH = 5,
  parameter int PIPE_LATENCY      = 3,
  parameter int IF_WIDTH          = clog2((2**BUFFER_ADDR_WIDTH) + PIPE_LATENCY + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pop,
  input  logic                         out_valid,
  input  logic                         clear_err,
  input  logic [BUFFER_ADDR_WIDTH:0]   outbuf_count,
  output logic [IF_WIDTH-1:0]          in_flight,
  output logic                         err_underflow,
  output logic                         credit_ok
);

  localparam int DEPTH = 2**BUFFER_ADDR_WIDTH;
  // Compare width is wide enough that count + in_flight + 1 can never wrap.
  localparam int CMP_W = (IF_WIDTH + 1 > BUFFER_ADDR_WIDTH + 2) ? IF_WIDTH + 1
                                                                : BUFFER_ADDR_WIDTH + 2;

  logic [CMP_W-1:0] credit_sum;
  logic             underflow;

  assign underflow  = out_valid && (in_flight == '0);
  assign credit_sum = CMP_W'(outbuf_count) + CMP_W'(in_flight) + CMP_W'(1);
  assign credit_ok  = (credit_sum <= CMP_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight     <= '0;
      err_underflow <= 1'b0;
    end else begin
      // A result with nothing outstanding is discarded rather than wrapping.
      if (underflow) begin
        in_flight <= in_flight + IF_WIDTH'(pop);
      end else if (pop && !out_valid) begin
        in_flight <= in_flight + IF_WIDTH'(1);
      end else if (!pop && out_valid) begin
        in_flight <= in_flight - IF_WIDTH'(1);
      end

      if (underflow) begin
        err_underflow <= 1'b1;
      end else if (clear_err) begin
        err_underflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_stream_ctrl.sv
`default_nettype none
// ============================================================================
// accel_stream_ctrl : job sequencer for inBuf -> multiplier -> outBuf with
//                     credit-gated input pops and completion signalling.
// Revision: 1.0
// ============================================================================
module accel_stream_ctrl
  import accel_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int BUFFER_ADDR_WIDTH = 5,
  parameter int PIPE_LATENCY      = 3,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         ACLK,
  input  logic                         RESET,
  input  logic                         start,
  input  logic [COUNT_WIDTH-1:0]       num_words,
  output logic                         busy,
  output logic                         done,
  output logic                         err_underflow,
  input  logic                         inBuf_empty,
  output logic                         inBuf_pop,
  input  logic [BUFFER_ADDR_WIDTH:0]   outBuf_count,
  input  logic                         outBuf_full,
  output logic                         dp_enable,
  input  logic                         dp_out_valid,
  output logic [COUNT_WIDTH-1:0]       words_left
);

  localparam int DEPTH    = 2**BUFFER_ADDR_WIDTH;
  localparam int IF_WIDTH = clog2(DEPTH + PIPE_LATENCY + 2);

  // Data never passes through this block; the width only documents the datapath.
  generate
    if (DATA_WIDTH < 1) begin : g_bad_data_width
    end
  endgenerate

  state_t                state;
  state_t                state_next;
  logic                  load_job;
  logic                  clear_err;
  logic                  credit_ok;
  logic [IF_WIDTH-1:0]   in_flight;

  accel_credit_counter #(
    .BUFFER_ADDR_WIDTH (BUFFER_ADDR_WIDTH),
    .PIPE_LATENCY      (PIPE_LATENCY),
    .IF_WIDTH          (IF_WIDTH)
  ) u_credit (
    .clk           (ACLK),
    .rst           (RESET),
    .pop           (inBuf_pop),
    .out_valid     (dp_out_valid),
    .clear_err     (clear_err),
    .outbuf_count  (outBuf_count),
    .in_flight     (in_flight),
    .err_underflow (err_underflow),
    .credit_ok     (credit_ok)
  );

  always_comb begin
    state_next = state;
    inBuf_pop  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_job   = 1'b0;
    clear_err  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_job   = 1'b1;
          clear_err  = 1'b1;
          state_next = (num_words == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        inBuf_pop = !inBuf_empty && (words_left != '0) && !outBuf_full && credit_ok;
        if (words_left == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // dp_enable still high means one more result has yet to be counted.
        if ((in_flight == '0) && !dp_enable) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      dp_enable  <= 1'b0;
      words_left <= '0;
    end else begin
      state     <= state_next;
      dp_enable <= inBuf_pop;
      if (load_job) begin
        words_left <= num_words;
      end else if (inBuf_pop) begin
        words_left <= words_left - COUNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_accel_stream_ctrl : directed self-checking bench with FIFO/datapath models
// Revision: 1.0
// ============================================================================
module tb_accel_stream_ctrl;

  localparam int BAW = 5;
  localparam int CW  = 16;

  logic          ACLK = 1'b0;
  logic          RESET;
  logic          start;
  logic [CW-1:0] num_words;
  logic          busy, done, err_underflow;
  logic          inBuf_empty, inBuf_pop;
  logic [BAW:0]  outBuf_count;
  logic          outBuf_full;
  logic          dp_enable, dp_out_valid;
  logic [CW-1:0] words_left;

  int   checks = 0;
  int   failures = 0;

  int   inbuf_words, outbuf_cnt;
  logic drain, ovr_en, ovr_val, inject_valid, model_valid;
  logic [1:0] pipe;
  int   n_pop, n_en, n_valid, n_done, n_busy, cyc, last_valid_cyc, overflow;

  assign inBuf_empty  = ovr_en ? ovr_val : (inbuf_words == 0);
  assign outBuf_count = (BAW+1)'(outbuf_cnt);
  assign outBuf_full  = (outbuf_cnt >= 32);
  assign dp_out_valid = model_valid | inject_valid;

  accel_stream_ctrl #(
    .DATA_WIDTH (64), .BUFFER_ADDR_WIDTH (BAW), .PIPE_LATENCY (3), .COUNT_WIDTH (CW)
  ) dut (
    .ACLK (ACLK), .RESET (RESET), .start (start), .num_words (num_words),
    .busy (busy), .done (done), .err_underflow (err_underflow),
    .inBuf_empty (inBuf_empty), .inBuf_pop (inBuf_pop),
    .outBuf_count (outBuf_count), .outBuf_full (outBuf_full),
    .dp_enable (dp_enable), .dp_out_valid (dp_out_valid), .words_left (words_left)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then advance FIFO and 3-cycle datapath models.
  task automatic step();
    logic s_pop, s_en, s_valid, s_drain;
    @(negedge ACLK);
    s_pop = inBuf_pop; s_en = dp_enable; s_valid = dp_out_valid; s_drain = drain;
    if (s_pop) n_pop++;
    if (s_en) n_en++;
    if (busy) n_busy++;
    if (done) n_done++;
    if (s_valid) begin n_valid++; last_valid_cyc = cyc; end
    @(posedge ACLK);
    #1;
    cyc++;
    if (s_pop && inbuf_words > 0) inbuf_words--;
    outbuf_cnt += int'(s_valid);
    if (s_drain && outbuf_cnt > 0) outbuf_cnt--;
    if (outbuf_cnt > 32) overflow = 1;
    model_valid = pipe[1];
    pipe = {pipe[0], s_en};
    #1;
  endtask

  task automatic clear_stats();
    n_pop = 0; n_en = 0; n_valid = 0; n_done = 0; n_busy = 0; overflow = 0;
  endtask

  task automatic wait_done(input int max_cycles);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cycles) begin
      step();
      k++;
    end
    check("done_timeout", done, 1);
  endtask

  logic pat [6]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic exp_pop [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int   exp_wl [6]  = '{3, 3, 2, 2, 2, 1};

  initial begin
    RESET = 1'b1; start = 1'b0; num_words = '0; drain = 1'b0; ovr_en = 1'b0; ovr_val = 1'b0;
    inject_valid = 1'b0; model_valid = 1'b0; pipe = 2'b00; inbuf_words = 0; outbuf_cnt = 0;
    cyc = 0; last_valid_cyc = 0; clear_stats();
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_underflow, 0);
    check("rst_dp_en", dp_enable, 0);
    check("rst_pop", inBuf_pop, 0);
    check("rst_words_left", words_left, 0);
    check("rst_in_flight", dut.u_credit.in_flight, 0);
    RESET = 1'b0;
    step();

    // Basic 4-word job
    inbuf_words = 4; outbuf_cnt = 0; clear_stats();
    start = 1'b1; num_words = 4; #1;
    check("t1_idle_busy", busy, 0);
    step(); start = 1'b0; #1;
    check("t1_c1_busy", busy, 1);
    check("t1_c1_pop", inBuf_pop, 1);
    check("t1_c1_dp_en", dp_enable, 0);
    check("t1_c1_wl", words_left, 4);
    step(); #1;
    check("t1_c2_pop", inBuf_pop, 1);
    check("t1_c2_dp_en", dp_enable, 1);
    check("t1_c2_wl", words_left, 3);
    step(); step(); #1;
    check("t1_c4_wl", words_left, 1);
    step(); #1;
    check("t1_c5_pop", inBuf_pop, 0);
    check("t1_c5_dp_en", dp_enable, 1);
    check("t1_c5_wl", words_left, 0);
    wait_done(20);
    check("t1_done_busy", busy, 0);
    check("t1_valid_to_done", cyc - last_valid_cyc, 2);
    check("t1_pops", n_pop, 4);
    check("t1_dp_en_cycles", n_en, 4);
    check("t1_valids", n_valid, 4);
    check("t1_busy_cycles", n_busy, 9);
    step(); #1;
    check("t1_done_once", done, 0);
    check("t1_done_count", n_done, 1);

    // Backpressure: outBuf nearly full
    inbuf_words = 5; outbuf_cnt = 30; drain = 1'b0; clear_stats();
    start = 1'b1; num_words = 5;
    step(); start = 1'b0; #1;
    check("t2_c1_pop", inBuf_pop, 1);
    step(); #1;
    check("t2_c2_pop", inBuf_pop, 1);
    step(); #1;
    check("t2_c3_pop", inBuf_pop, 0);
    check("t2_c3_in_flight", dut.u_credit.in_flight, 2);
    repeat (6) step();
    #1;
    check("t2_stall_pops", n_pop, 2);
    check("t2_stall_pop", inBuf_pop, 0);
    check("t2_stall_in_flight", dut.u_credit.in_flight, 0);
    check("t2_stall_outbuf", outbuf_cnt, 32);
    drain = 1'b1;
    step(); step(); step();
    drain = 1'b0;
    wait_done(60);
    check("t2_pops", n_pop, 5);
    check("t2_valids", n_valid, 5);
    check("t2_no_overflow", overflow, 0);
    step();

    // Empty starvation
    outbuf_cnt = 0; ovr_en = 1'b1; ovr_val = 1'b1; clear_stats();
    start = 1'b1; num_words = 3;
    for (int i = 0; i < 6; i++) begin
      step(); start = 1'b0; ovr_val = pat[i]; #1;
      check($sformatf("t3_pop_%0d", i), inBuf_pop, exp_pop[i]);
      check($sformatf("t3_wl_%0d", i), words_left, exp_wl[i]);
    end
    step(); ovr_val = 1'b1; #1;
    check("t3_wl_end", words_left, 0);
    check("t3_state_run", dut.state, 1);
    ovr_en = 1'b0;
    wait_done(20);
    check("t3_pops", n_pop, 3);
    step();

    // Zero-length job
    clear_stats();
    start = 1'b1; num_words = 0;
    step(); start = 1'b0; #1;
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_pop", inBuf_pop, 0);
    step(); #1;
    check("t4_done_clear", done, 0);
    check("t4_no_dp_en", n_en, 0);
    check("t4_no_pop", n_pop, 0);

    // Underflow in IDLE, then simultaneous pop and result
    inject_valid = 1'b1;
    step(); inject_valid = 1'b0; #1;
    check("t5_err_set", err_underflow, 1);
    check("t5_in_flight_hold", dut.u_credit.in_flight, 0);
    ovr_en = 1'b1; ovr_val = 1'b0; start = 1'b1; num_words = 2;
    step(); start = 1'b0; #1;
    check("t5_err_cleared", err_underflow, 0);
    check("t5_c1_pop", inBuf_pop, 1);
    step(); ovr_val = 1'b1;
    step(); step();
    step(); ovr_val = 1'b0; #1;
    check("t5_c5_pop", inBuf_pop, 1);
    check("t5_c5_valid", dp_out_valid, 1);
    check("t5_c5_in_flight", dut.u_credit.in_flight, 1);
    step(); #1;
    check("t5_c6_in_flight", dut.u_credit.in_flight, 1);
    ovr_en = 1'b0;
    wait_done(20);
    check("t5_err_end", err_underflow, 0);
    step();

    // Reset mid-job
    inbuf_words = 20; outbuf_cnt = 0; clear_stats();
    start = 1'b1; num_words = 10;
    step(); start = 1'b0;
    step(); step(); step(); #1;
    check("t6_wl", words_left, 7);
    check("t6_pop_before", inBuf_pop, 1);
    RESET = 1'b1; #1;
    check("t6_async_pop", inBuf_pop, 0);
    check("t6_async_dp_en", dp_enable, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_in_flight", dut.u_credit.in_flight, 0);
    check("t6_async_wl", words_left, 0);
    step(); RESET = 1'b0;
    repeat (6) step();
    #1;
    check("t6_idle", dut.state, 0);
    inbuf_words = 1; outbuf_cnt = 0;
    start = 1'b1; num_words = 1;
    step(); start = 1'b0; #1;
    check("t6_restart_busy", busy, 1);
    check("t6_restart_err", err_underflow, 0);
    wait_done(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
